// File: rtl/trap_sequencer.sv
// Trap sequencer: picks one exception/interrupt by fixed priority, drains the pipeline,
// hands a single request to trap_handler and redirects fetch. Optional: TRAP_SEQ_VECTORED_EN.
module trap_sequencer #(
  parameter int NUM_SRC       = 4,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     exc_valid,
  input  logic [4*NUM_SRC-1:0]   exc_code_in,
  input  logic [64*NUM_SRC-1:0]  exc_val_in,
  input  logic [64*NUM_SRC-1:0]  exc_pc_in,
  input  logic [15:0]            irq_pending,
  input  logic [15:0]            irq_enable,
  input  logic [63:0]            irq_pc,
  input  logic                   mstatus_mie,
  input  logic [1:0]             priv_lvl,
  input  logic [63:0]            mtvec,
  input  logic                   mret_req,
  input  logic                   drain_ack,
  input  logic                   trap_taken,
  input  logic                   pc_ret_taken,
  input  logic [63:0]            pc_ret,
  output logic                   exc_en,
  output logic                   irq_en,
  output logic                   mret,
  output logic [3:0]             exc_code,
  output logic [3:0]             irq_code,
  output logic [63:0]            exc_val,
  output logic [63:0]            irq_val,
  output logic [63:0]            pc_addr,
  output logic                   stall,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [63:0]            redirect_pc,
  output logic                   busy,
  output logic                   drain_timeout
);

  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_ISSUE, S_WAIT, S_REDIR, S_RET_ISSUE, S_RET_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic           is_irq_q, dto_q;
  logic [3:0]     exc_code_q, irq_code_q;
  logic [63:0]    exc_val_q, irq_val_q, pc_addr_q, target_q;

  logic           exc_hit, irq_hit, trap_sel, cnt_done;
  logic [3:0]     sel_code, irq_sel;
  logic [63:0]    sel_val, sel_pc, trap_target;
  logic [15:0]    irq_masked;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    exc_hit  = |exc_valid;
    sel_code = '0;
    sel_val  = '0;
    sel_pc   = '0;
    // Ascending scan: the last hit (oldest stage / highest cause) wins.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (exc_valid[i]) begin
        sel_code = exc_code_in[4*i +: 4];
        sel_val  = exc_val_in[64*i +: 64];
        sel_pc   = exc_pc_in[64*i +: 64];
      end
    end
    irq_masked = irq_pending & irq_enable;
    irq_hit    = (|irq_masked) && (mstatus_mie || (priv_lvl != 2'b11));
    irq_sel    = '0;
    for (int i = 0; i < 16; i++) begin
      if (irq_masked[i]) irq_sel = 4'(i);
    end
  end

  assign trap_sel = exc_hit || irq_hit;
  assign cnt_done = (cnt_q == CW'(DRAIN_TIMEOUT - 1));

`ifdef TRAP_SEQ_VECTORED_EN
  always_comb begin
    trap_target = {mtvec[63:2], 2'b00};
    if (is_irq_q && (mtvec[1:0] == 2'b01))
      trap_target = {mtvec[63:2], 2'b00} + {58'd0, irq_code_q, 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = ^mtvec[1:0];
  assign trap_target = {mtvec[63:2], 2'b00};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (trap_sel)      state_d = S_DRAIN;
        else if (mret_req) state_d = S_RET_ISSUE;
      end
      S_DRAIN:     if (drain_ack || cnt_done) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT;
      S_WAIT:      if (trap_taken) state_d = S_REDIR;
      S_REDIR:     state_d = S_IDLE;
      S_RET_ISSUE: state_d = S_RET_WAIT;
      S_RET_WAIT:  if (pc_ret_taken) state_d = S_REDIR;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      is_irq_q   <= 1'b0;
      dto_q      <= 1'b0;
      exc_code_q <= '0;
      irq_code_q <= '0;
      exc_val_q  <= '0;
      irq_val_q  <= '0;
      pc_addr_q  <= '0;
      target_q   <= '0;
    end else begin
      if (state_q == S_IDLE && trap_sel) begin
        is_irq_q <= !exc_hit;
        cnt_q    <= '0;
        if (exc_hit) begin
          exc_code_q <= sel_code;
          exc_val_q  <= sel_val;
          pc_addr_q  <= sel_pc;
        end else begin
          irq_code_q <= irq_sel;
          irq_val_q  <= '0;
          pc_addr_q  <= irq_pc;
        end
      end
      if (state_q == S_DRAIN) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_done && !drain_ack) dto_q <= 1'b1;
      end
      if (state_q == S_WAIT && trap_taken)       target_q <= trap_target;
      if (state_q == S_RET_WAIT && pc_ret_taken) target_q <= pc_ret;
    end
  end

  always_comb begin
    exc_en         = (state_q == S_ISSUE) && !is_irq_q;
    irq_en         = (state_q == S_ISSUE) && is_irq_q;
    mret           = (state_q == S_RET_ISSUE);
    stall          = (state_q != S_IDLE) && (state_q != S_REDIR);
    busy           = (state_q != S_IDLE);
    flush          = (state_q == S_REDIR);
    redirect_valid = (state_q == S_REDIR);
    redirect_pc    = (state_q == S_REDIR) ? target_q : 64'd0;
  end

  assign exc_code      = exc_code_q;
  assign irq_code      = irq_code_q;
  assign exc_val       = exc_val_q;
  assign irq_val       = irq_val_q;
  assign pc_addr       = pc_addr_q;
  assign drain_timeout = dto_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer; a small trap_handler responder
// returns acknowledges one cycle after each request.
module tb_trap_sequencer;
  logic         clk, rst;
  logic [3:0]   exc_valid;
  logic [15:0]  exc_code_in;
  logic [255:0] exc_val_in, exc_pc_in;
  logic [15:0]  irq_pending, irq_enable;
  logic [63:0]  irq_pc, mtvec, pc_ret;
  logic         mstatus_mie, mret_req, drain_ack, trap_taken, pc_ret_taken;
  logic [1:0]   priv_lvl;
  logic         exc_en, irq_en, mret, stall, flush, redirect_valid, busy, drain_timeout;
  logic [3:0]   exc_code, irq_code;
  logic [63:0]  exc_val, irq_val, pc_addr, redirect_pc;

  int vectors = 0, miscompares = 0;

  // Per-run observations
  int n_exc, n_irq, n_mret, n_redir, n_overlap, n_busy_bad, n_busy;
  int first_req, first_mret, first_stall, first_dto, redir_cyc;
  logic [3:0]  code_seen;
  logic [63:0] pc_seen, val_seen, redir_pc_seen;
  logic        stall_at_redir;

  trap_sequencer dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code_in(exc_code_in),
    .exc_val_in(exc_val_in), .exc_pc_in(exc_pc_in), .irq_pending(irq_pending),
    .irq_enable(irq_enable), .irq_pc(irq_pc), .mstatus_mie(mstatus_mie),
    .priv_lvl(priv_lvl), .mtvec(mtvec), .mret_req(mret_req), .drain_ack(drain_ack),
    .trap_taken(trap_taken), .pc_ret_taken(pc_ret_taken), .pc_ret(pc_ret),
    .exc_en(exc_en), .irq_en(irq_en), .mret(mret), .exc_code(exc_code),
    .irq_code(irq_code), .exc_val(exc_val), .irq_val(irq_val), .pc_addr(pc_addr),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .drain_timeout(drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs ncyc clocks after the inputs were set; cycle 1 is the first edge that sees them.
  task automatic run_seq(input int ncyc, input bit respond);
    bit req_d = 1'b0, ret_d = 1'b0;
    n_exc = 0; n_irq = 0; n_mret = 0; n_redir = 0; n_overlap = 0; n_busy_bad = 0; n_busy = 0;
    first_req = -1; first_mret = -1; first_stall = -1; first_dto = -1; redir_cyc = -1;
    code_seen = '0; pc_seen = '0; val_seen = '0; redir_pc_seen = '0; stall_at_redir = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (int'(exc_en) + int'(irq_en) + int'(mret) > 1) n_overlap++;
      if (busy !== (stall | redirect_valid)) n_busy_bad++;
      if (busy) n_busy++;
      if (stall && first_stall < 0) first_stall = c;
      if (drain_timeout && first_dto < 0) first_dto = c;
      if (exc_en) begin
        n_exc++; code_seen = exc_code; pc_seen = pc_addr; val_seen = exc_val;
        if (first_req < 0) first_req = c;
      end
      if (irq_en) begin
        n_irq++; code_seen = irq_code; pc_seen = pc_addr; val_seen = irq_val;
        if (first_req < 0) first_req = c;
      end
      if (mret) begin
        n_mret++;
        if (first_mret < 0) first_mret = c;
      end
      if (redirect_valid) begin
        n_redir++; redir_pc_seen = redirect_pc; stall_at_redir = stall;
        if (redir_cyc < 0) redir_cyc = c;
        exc_valid = '0; irq_pending = '0; mret_req = 1'b0;
      end
      if (respond) begin
        trap_taken = req_d;   req_d = exc_en | irq_en;
        pc_ret_taken = ret_d; ret_d = mret;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; exc_valid = '0; exc_code_in = '0; exc_val_in = '0; exc_pc_in = '0;
    irq_pending = '0; irq_enable = '0; irq_pc = '0; mtvec = '0; pc_ret = '0;
    mstatus_mie = 1'b0; mret_req = 1'b0; drain_ack = 1'b0; trap_taken = 1'b0;
    pc_ret_taken = 1'b0; priv_lvl = 2'b11;
    step(); step();
    vectors++; if ({busy, stall, flush, redirect_valid, exc_en, irq_en, mret, drain_timeout} !== 8'h00) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 00000000", {busy, stall, flush, redirect_valid, exc_en, irq_en, mret, drain_timeout}); end
    vectors++; if ({exc_code, irq_code, exc_val, irq_val, pc_addr, redirect_pc} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", {exc_code, irq_code, exc_val, irq_val, pc_addr, redirect_pc}); end
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_single_exc();
    exc_valid = 4'b0001; exc_code_in[3:0] = 4'd2; exc_pc_in[63:0] = 64'h100;
    exc_val_in[63:0] = 64'hDEAD; drain_ack = 1'b1; mtvec = 64'h200;
    run_seq(8, 1'b1);
    vectors++; if (n_exc !== 1) begin miscompares++; $display("FAIL single_exc_pulses: got %0d want 1", n_exc); end
    vectors++; if (first_stall !== 1) begin miscompares++; $display("FAIL single_stall_cycle: got %0d want 1", first_stall); end
    vectors++; if (first_req !== 2) begin miscompares++; $display("FAIL single_req_cycle: got %0d want 2", first_req); end
    vectors++; if (code_seen !== 4'd2) begin miscompares++; $display("FAIL single_code: got %0d want 2", code_seen); end
    vectors++; if (pc_seen !== 64'h100) begin miscompares++; $display("FAIL single_pc: got %h want 100", pc_seen); end
    vectors++; if (val_seen !== 64'hDEAD) begin miscompares++; $display("FAIL single_val: got %h want dead", val_seen); end
    vectors++; if (redir_cyc !== 4) begin miscompares++; $display("FAIL single_redir_cycle: got %0d want 4", redir_cyc); end
    vectors++; if (redir_pc_seen !== 64'h200) begin miscompares++; $display("FAIL single_redir_pc: got %h want 200", redir_pc_seen); end
    vectors++; if (n_redir !== 1 || stall_at_redir !== 1'b0) begin
      miscompares++; $display("FAIL single_redir_once: got n=%0d stall=%b want n=1 stall=0", n_redir, stall_at_redir); end
    vectors++; if (n_overlap !== 0 || n_busy_bad !== 0 || n_irq !== 0) begin
      miscompares++; $display("FAIL single_hygiene: got overlap=%0d busybad=%0d irq=%0d want 0 0 0", n_overlap, n_busy_bad, n_irq); end
    vectors++; if (drain_timeout !== 1'b0) begin miscompares++; $display("FAIL single_no_timeout: got %b want 0", drain_timeout); end
  endtask

  task automatic test_exc_priority();
    exc_valid = 4'b1001; exc_code_in[15:12] = 4'd5; exc_pc_in[255:192] = 64'h40;
    irq_pending = 16'h0080; irq_enable = 16'h0080; mstatus_mie = 1'b1; irq_pc = 64'h300;
    run_seq(8, 1'b1);
    vectors++; if (n_exc !== 1 || n_irq !== 0) begin
      miscompares++; $display("FAIL prio_pulses: got exc=%0d irq=%0d want exc=1 irq=0", n_exc, n_irq); end
    vectors++; if (code_seen !== 4'd5) begin miscompares++; $display("FAIL prio_code: got %0d want 5", code_seen); end
    vectors++; if (pc_seen !== 64'h40) begin miscompares++; $display("FAIL prio_pc: got %h want 40", pc_seen); end
  endtask

  task automatic test_irq_gating();
    logic [63:0] exp_pc;
    irq_pending = 16'h0880; irq_enable = 16'h0880; mstatus_mie = 1'b0; priv_lvl = 2'b11;
    irq_pc = 64'h300; mtvec = 64'h201;
    run_seq(5, 1'b1);
    vectors++; if (n_busy !== 0) begin miscompares++; $display("FAIL irq_masked_idle: got busy cycles %0d want 0", n_busy); end
    mstatus_mie = 1'b1;
    run_seq(8, 1'b1);
`ifdef TRAP_SEQ_VECTORED_EN
    exp_pc = 64'h22C;
`else
    exp_pc = 64'h200;
`endif
    vectors++; if (n_irq !== 1 || n_exc !== 0 || first_req !== 2) begin
      miscompares++; $display("FAIL irq_pulse: got irq=%0d exc=%0d cyc=%0d want 1 0 2", n_irq, n_exc, first_req); end
    vectors++; if (code_seen !== 4'd11) begin miscompares++; $display("FAIL irq_code: got %0d want 11", code_seen); end
    vectors++; if (pc_seen !== 64'h300 || val_seen !== 64'h0) begin
      miscompares++; $display("FAIL irq_pc_val: got pc=%h val=%h want 300 0", pc_seen, val_seen); end
    vectors++; if (redir_pc_seen !== exp_pc || redir_cyc !== 4) begin
      miscompares++; $display("FAIL irq_redirect: got pc=%h cyc=%0d want %h 4", redir_pc_seen, redir_cyc, exp_pc); end
    // Below machine mode the interrupt is taken even with MIE clear.
    mstatus_mie = 1'b0; priv_lvl = 2'b00; irq_pending = 16'h0004; irq_enable = 16'h0004;
    run_seq(8, 1'b1);
    vectors++; if (n_irq !== 1 || code_seen !== 4'd2) begin
      miscompares++; $display("FAIL irq_low_priv: got irq=%0d code=%0d want 1 2", n_irq, code_seen); end
    priv_lvl = 2'b11; irq_enable = '0; mtvec = 64'h200;
  endtask

  task automatic test_mret();
    mret_req = 1'b1; pc_ret = 64'h114;
    run_seq(7, 1'b1);
    vectors++; if (n_mret !== 1 || first_mret !== 1) begin
      miscompares++; $display("FAIL mret_pulse: got n=%0d cyc=%0d want 1 1", n_mret, first_mret); end
    vectors++; if (redir_cyc !== 3 || redir_pc_seen !== 64'h114) begin
      miscompares++; $display("FAIL mret_redirect: got cyc=%0d pc=%h want 3 114", redir_cyc, redir_pc_seen); end
    vectors++; if (stall_at_redir !== 1'b0 || n_exc !== 0 || n_overlap !== 0 || n_busy_bad !== 0) begin
      miscompares++; $display("FAIL mret_hygiene: got stall=%b exc=%0d ovl=%0d bb=%0d want 0 0 0 0", stall_at_redir, n_exc, n_overlap, n_busy_bad); end
  endtask

  task automatic test_drain_timeout();
    exc_valid = 4'b0001; drain_ack = 1'b0;
    run_seq(24, 1'b1);
    vectors++; if (first_req !== 17 || n_exc !== 1) begin
      miscompares++; $display("FAIL dto_req_cycle: got cyc=%0d n=%0d want 17 1", first_req, n_exc); end
    vectors++; if (first_dto !== 17) begin miscompares++; $display("FAIL dto_flag_cycle: got %0d want 17", first_dto); end
    vectors++; if (redir_cyc !== 19) begin miscompares++; $display("FAIL dto_redir_cycle: got %0d want 19", redir_cyc); end
    vectors++; if (drain_timeout !== 1'b1) begin miscompares++; $display("FAIL dto_sticky: got %b want 1", drain_timeout); end
    drain_ack = 1'b1;
  endtask

  task automatic test_reset_mid();
    exc_valid = 4'b0001;
    run_seq(3, 1'b0);
    vectors++; if (stall !== 1'b1 || exc_en !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_in_wait: got stall=%b exc_en=%b want 1 0", stall, exc_en); end
    #2 rst = 1'b1;
    #1;
    vectors++; if ({busy, stall, flush, redirect_valid, exc_en, drain_timeout} !== 6'b0) begin
      miscompares++; $display("FAIL rstmid_ctrl: got %b want 000000", {busy, stall, flush, redirect_valid, exc_en, drain_timeout}); end
    vectors++; if ({exc_code, pc_addr, exc_val, redirect_pc} !== '0) begin
      miscompares++; $display("FAIL rstmid_data: got %h want 0", {exc_code, pc_addr, exc_val, redirect_pc}); end
    @(negedge clk);
    rst = 1'b0; exc_valid = '0; trap_taken = 1'b1;
    run_seq(6, 1'b1);
    vectors++; if (n_redir !== 0 || n_exc !== 0 || n_busy !== 0) begin
      miscompares++; $display("FAIL rstmid_no_stray: got redir=%0d exc=%0d busy=%0d want 0 0 0", n_redir, n_exc, n_busy); end
  endtask

  initial begin
    test_reset();
    test_single_exc();
    test_exc_priority();
    test_irq_gating();
    test_mret();
    test_drain_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
